sdram_frame_reader: RTL and testbench
=====================================

# sdram_frame_reader

Avalon-MM read master that streams one frame of 16-bit words out of the SDRAM controller's `s1` slave and presents them as a valid/ready pixel stream to the SLM display path. It sits directly downstream of the SDRAM controller in `reader_system`. It issues pipelined word reads, tracks outstanding requests, and buffers returned data in an internal FIFO. A credit scheme guarantees that returned data is never dropped, even when the display side stalls.

## Interface
Parameters:
- `ADDR_W`, 25: word address width; matches `sdram_controller_0_s1_address`.
- `DATA_W`, 16: data width.
- `FIFO_DEPTH`, 16: depth of the return-data FIFO. Must be a power of 2, ≥4.
- `MAX_PEND`, 8: maximum number of outstanding reads. Must be ≤ `FIFO_DEPTH`.

Ports:
- `clk_clk`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `reset_reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a frame. Ignored while `busy`=1.
- `base_addr`  in  ADDR_W  first word address. Sampled on `start`.
- `word_count`  in  ADDR_W  number of words in the frame. Sampled on `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last word is accepted downstream.
- `m_address`  out  ADDR_W  read address.
- `m_byteenable_n`  out  2  constant 2'b00.
- `m_chipselect`  out  1  equals ~`m_read_n`.
- `m_writedata`  out  DATA_W  constant 0.
- `m_read_n`  out  1  active-low read request.
- `m_write_n`  out  1  constant 1.
- `m_readdata`  in  DATA_W  returned data.
- `m_readdatavalid`  in  1  return strobe.
- `m_waitrequest`  in  1  slave stall.
- `out_data`  out  DATA_W  stream data (FIFO head).
- `out_valid`  out  1  FIFO is non-empty and a frame is active.
- `out_ready`  in  1  downstream accepts the word when `out_valid`&&`out_ready`.

## Operation
- State machine: IDLE → ISSUE → DRAIN → DONE → IDLE.
- IDLE:
  - `start` latches `base_addr` into `addr` and `word_count` into `issue_left` and `recv_left`.
  - If `word_count`=0, go to DONE and issue no reads. Otherwise go to ISSUE.
- ISSUE:
  - `m_read_n`=0 whenever the credit condition holds: `issue_left`≠0, `pend`<`MAX_PEND`, and `pend`+`fifo_cnt`<`FIFO_DEPTH`.
  - A request is accepted when `m_read_n`=0 and `m_waitrequest`=0. On acceptance: `addr`+=1, `issue_left`-=1, `pend`+=1.
  - While `m_waitrequest`=1, `m_address` and `m_read_n` stay stable. A request, once asserted, is never withdrawn.
  - When `issue_left` reaches 0, go to DRAIN.
- Return path:
  - Each `m_readdatavalid` pushes `m_readdata` into the FIFO and decrements `pend`.
  - Pushes and pops in the same cycle are legal, including when the FIFO is full or empty.
  - Credit makes overflow impossible. An overflow push is an assertion failure in simulation.
- DRAIN: when `recv_left`=0 (decremented on each pop), go to DONE.
- DONE: pulse `done` for one cycle, clear `busy`, return to IDLE.
- `pend` counts simultaneous acceptance and return as a net change of 0.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Reset mid-frame:
  - All state, counters and FIFO pointers clear.
  - Any `m_readdatavalid` received in IDLE is discarded (the controller shares the reset).

## Timing
Reset values:
- `busy`=0, `done`=0, `m_read_n`=1, `m_chipselect`=0, `m_address`=0, `out_valid`=0.

Latency and throughput:
- `start` is sampled in cycle 0. `busy`=1 and the first `m_read_n`=0 appear in cycle 1.
- Sustained throughput is 1 word/cycle when `waitrequest`=0, `out_ready`=1 and the read latency is < `MAX_PEND`.
- FIFO write to `out_valid` takes 1 cycle (registered FIFO, first-word-fall-through at head).
- `done` asserts the cycle after the final stream handshake. A new `start` is accepted the cycle after `done`.
- For `word_count`=0, `done` asserts in cycle 1 and `busy` stays 0.
- `out_data` must hold stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Basic frame:
  - Stimulus: `base_addr`=0x100, `word_count`=4, 2-cycle read latency, `out_ready`=1.
  - Required: reads at 0x100–0x103 in 4 consecutive cycles; out_data equals the memory model at 0x100..0x103, in order; `done` asserts exactly once.
- Backpressure:
  - Stimulus: `word_count`=64, `out_ready`=0 for 40 cycles, then 1.
  - Required: outstanding requests never exceed `MAX_PEND`, and `pend`+`fifo_cnt` never exceeds 16; no data is lost; all 64 words arrive in order.
- Waitrequest:
  - Stimulus: `waitrequest` asserted randomly at 50%, `word_count`=32.
  - Required: `m_address` and `m_read_n` are stable during stalls; exactly 32 reads are accepted.
- Edge cases:
  - `word_count`=0: `done` asserts at cycle 1 with no reads.
  - `base_addr`=0x1FFFFFE, `word_count`=4: addresses 0x1FFFFFE, 0x1FFFFFF, 0x0, 0x1.
- Reset and start handling:
  - Reset asserted mid-frame (after 10 of 100 words): all outputs return to reset values the next cycle.
  - A fresh `start` afterwards completes correctly.
  - A `start` pulse while `busy` is ignored.

Source files
------------

// File: rtl/sdram_frame_reader_if.sv
// Bundle of the frame-reader's control, Avalon-MM read-master and pixel-stream signals.
// master = frame reader side, slave = system side (controller, display path, sequencer).
interface sdram_frame_reader_if #(
   parameter int ADDR_W = 25,
   parameter int DATA_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic [ADDR_W-1:0] word_count;
   logic              busy;
   logic              done;

   logic [ADDR_W-1:0] m_address;
   logic [1:0]        m_byteenable_n;
   logic              m_chipselect;
   logic [DATA_W-1:0] m_writedata;
   logic              m_read_n;
   logic              m_write_n;
   logic [DATA_W-1:0] m_readdata;
   logic              m_readdatavalid;
   logic              m_waitrequest;

   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   // Handshakes: a read is accepted on a clock edge where m_read_n=0 and m_waitrequest=0, and
   // a request stays asserted with a stable address until accepted; a stream word moves on an
   // edge where out_valid=1 and out_ready=1, out_valid never waits on out_ready, and out_data
   // holds while out_valid=1 and out_ready=0.
   modport master (
      input  start, base_addr, word_count, m_readdata, m_readdatavalid, m_waitrequest, out_ready,
      output busy, done, m_address, m_byteenable_n, m_chipselect, m_writedata, m_read_n,
      output m_write_n, out_data, out_valid
   );

   modport slave (
      output start, base_addr, word_count, m_readdata, m_readdatavalid, m_waitrequest, out_ready,
      input  busy, done, m_address, m_byteenable_n, m_chipselect, m_writedata, m_read_n,
      input  m_write_n, out_data, out_valid
   );
endinterface

// File: rtl/sdram_frame_reader.sv
// Streams one frame of words from the SDRAM controller to the display path using pipelined
// reads; a credit limit on outstanding reads plus buffered words keeps the return FIFO from overflowing.
module sdram_frame_reader #(
   parameter int ADDR_W     = 25,
   parameter int DATA_W     = 16,
   parameter int FIFO_DEPTH = 16,
   parameter int MAX_PEND   = 8
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset,
   sdram_frame_reader_if.master bus,
   output logic [1:0]           dbg_state_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [CW-1:0]     MAX_PEND_C = CW'(MAX_PEND);
   localparam logic [CW:0]       DEPTH_C    = (CW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]     FULL_C     = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0]     ONE_C      = CW'(1);
   localparam logic [ADDR_W-1:0] ONE_A      = ADDR_W'(1);
   localparam logic [PW-1:0]     ONE_P      = PW'(1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] issue_left_q, issue_left_d;
   logic [ADDR_W-1:0] recv_left_q, recv_left_d;
   logic [CW-1:0]     pend_q, pend_d;
   logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic          busy;
   logic          credit;
   logic          req;
   logic          accept;
   logic          push;
   logic          pop;
   logic [CW:0]   occupancy;

   // Every issued read owns a FIFO slot until its word leaves downstream.
   assign occupancy = {1'b0, pend_q} + {1'b0, fifo_cnt_q};
   assign credit    = (issue_left_q != '0) && (pend_q < MAX_PEND_C) && (occupancy < DEPTH_C);
   assign req       = (state_q == S_ISSUE) && credit;
   assign accept    = req && !bus.m_waitrequest;
   assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
   assign push      = bus.m_readdatavalid && (state_q != S_IDLE);
   assign pop       = busy && (fifo_cnt_q != '0) && bus.out_ready;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      issue_left_d = issue_left_q;
      recv_left_d  = pop ? recv_left_q - ONE_A : recv_left_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               addr_d       = bus.base_addr;
               issue_left_d = bus.word_count;
               recv_left_d  = bus.word_count;
               state_d      = (bus.word_count == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (accept) begin
               addr_d       = addr_q + ONE_A;
               issue_left_d = issue_left_q - ONE_A;
               if (issue_left_q == ONE_A) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if ((recv_left_q == '0) || (pop && (recv_left_q == ONE_A))) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      pend_d = pend_q;
      if (accept && !push)      pend_d = pend_q + ONE_C;
      else if (!accept && push) pend_d = pend_q - ONE_C;
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop)         fifo_cnt_d = fifo_cnt_q + ONE_C;
      else if (!push && pop)    fifo_cnt_d = fifo_cnt_q - ONE_C;
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         issue_left_q <= '0;
         recv_left_q  <= '0;
         pend_q       <= '0;
         fifo_cnt_q   <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         issue_left_q <= issue_left_d;
         recv_left_q  <= recv_left_d;
         pend_q       <= pend_d;
         fifo_cnt_q   <= fifo_cnt_d;
         if (push) wr_ptr_q <= wr_ptr_q + ONE_P;
         if (pop)  rd_ptr_q <= rd_ptr_q + ONE_P;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.m_readdata;
   end

   overflow_never: assert property (@(posedge clk_clk) disable iff (reset_reset)
      !(push && !pop && (fifo_cnt_q == FULL_C)));

   assign bus.busy           = busy;
   assign bus.done           = (state_q == S_DONE);
   assign bus.m_address      = addr_q;
   assign bus.m_byteenable_n = 2'b00;
   assign bus.m_chipselect   = req;
   assign bus.m_writedata    = '0;
   assign bus.m_read_n       = ~req;
   assign bus.m_write_n      = 1'b1;
   assign bus.out_data       = mem_q[rd_ptr_q];
   assign bus.out_valid      = busy && (fifo_cnt_q != '0);
   assign dbg_state_o        = state_q;
endmodule

// File: tb/tb_sdram_frame_reader.sv
// Directed bench for sdram_frame_reader: SDRAM slave model with latency/waitrequest,
// stream sink with programmable backpressure, scenario tasks with inline checks.
module tb_sdram_frame_reader;
   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   sdram_frame_reader_if #(.ADDR_W(25), .DATA_W(16)) bus ();

   sdram_frame_reader #(
      .ADDR_W(25), .DATA_W(16), .FIFO_DEPTH(16), .MAX_PEND(8)
   ) dut (
      .clk_clk     (clk),
      .reset_reset (rst),
      .bus         (bus.master),
      .dbg_state_o (dbg_state)
   );

   int checks = 0;
   int errors = 0;

   int cyc      = 0;
   int latency  = 2;
   bit wait_en  = 0;
   int ready_at = 0;

   int n_acc, n_ret, n_pop, n_done, max_pend, max_occ, stall_viol, last_pop_cyc, done_cyc;
   logic [24:0] acc_addr[$];
   int          acc_cyc[$];
   logic [15:0] got_q[$];
   logic [15:0] exp_q[$];
   logic [24:0] exp_addr_q[$];
   logic [24:0] rq_addr[$];
   int          rq_due[$];
   bit          prev_stall;
   logic [24:0] prev_addr;
   logic        busy_c1, readn_c1, done_c1;
   bit          timeout;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] mem_word(input logic [24:0] a);
      logic [15:0] p;
      p = a[15:0] * 16'd37;
      return p ^ {7'd0, a[24:16]} ^ 16'hC3A5;
   endfunction

   // Slave model and stream sink, evaluated mid-cycle while DUT outputs are settled.
   initial begin
      bus.m_waitrequest   = 1'b0;
      bus.m_readdatavalid = 1'b0;
      bus.m_readdata      = '0;
      bus.out_ready       = 1'b0;
      prev_stall          = 1'b0;
      prev_addr           = '0;
      forever begin
         @(negedge clk);
         cyc = cyc + 1;
         bus.m_waitrequest = wait_en ? 1'($urandom_range(0, 1)) : 1'b0;
         bus.out_ready     = (cyc >= ready_at);
         if (prev_stall && (bus.m_read_n !== 1'b0 || bus.m_address !== prev_addr))
            stall_viol++;
         prev_stall = (bus.m_read_n === 1'b0) && bus.m_waitrequest;
         prev_addr  = bus.m_address;
         bus.m_readdatavalid = 1'b0;
         bus.m_readdata      = '0;
         if (rq_due.size() > 0 && rq_due[0] <= cyc) begin
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = mem_word(rq_addr[0]);
            void'(rq_addr.pop_front());
            void'(rq_due.pop_front());
            n_ret++;
         end
         if (bus.m_read_n === 1'b0 && !bus.m_waitrequest) begin
            n_acc++;
            acc_addr.push_back(bus.m_address);
            acc_cyc.push_back(cyc);
            rq_addr.push_back(bus.m_address);
            rq_due.push_back(cyc + latency);
         end
         if (bus.out_valid === 1'b1 && bus.out_ready) begin
            got_q.push_back(bus.out_data);
            n_pop++;
            last_pop_cyc = cyc;
         end
         if (bus.done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
         end
         if (n_acc - n_ret > max_pend) max_pend = n_acc - n_ret;
         if (n_acc - n_pop > max_occ)  max_occ  = n_acc - n_pop;
      end
   end

   task automatic clear_scoreboard();
      n_acc = 0; n_ret = 0; n_pop = 0; n_done = 0;
      max_pend = 0; max_occ = 0; stall_viol = 0; last_pop_cyc = -1; done_cyc = -1;
      acc_addr.delete(); acc_cyc.delete(); got_q.delete(); exp_q.delete(); exp_addr_q.delete();
   endtask

   // Starts a frame in the current cycle and returns in the cycle after done.
   task automatic run_frame(input logic [24:0] base, input logic [24:0] cnt, input int lat,
                            input bit wen, input int rdelay, input int spur_at);
      latency  = lat;
      wait_en  = wen;
      ready_at = cyc + rdelay;
      clear_scoreboard();
      for (int i = 0; i < int'(cnt); i++) begin
         exp_addr_q.push_back(base + 25'(i));
         exp_q.push_back(mem_word(base + 25'(i)));
      end
      bus.base_addr  = base;
      bus.word_count = cnt;
      bus.start      = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      busy_c1  = bus.busy;
      readn_c1 = bus.m_read_n;
      done_c1  = bus.done;
      timeout  = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (bus.done === 1'b1) begin
            timeout = 1'b0;
            break;
         end
         bus.start = (i == spur_at);
         if (i == spur_at) begin
            bus.base_addr  = 25'h900;
            bus.word_count = 25'd2;
         end
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      wait_en   = 1'b0;
      @(posedge clk); #1;
   endtask

   function automatic int count_data_errors();
      int bad = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
         if (i >= acc_addr.size() || acc_addr[i] !== exp_addr_q[i]) bad++;
      end
      return bad;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done); end
      checks++; if (bus.m_read_n !== 1'b1) begin errors++; $display("FAIL reset_read_n: got %0b want 1", bus.m_read_n); end
      checks++; if (bus.m_chipselect !== 1'b0) begin errors++; $display("FAIL reset_cs: got %0b want 0", bus.m_chipselect); end
      checks++; if (bus.m_address !== 25'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", bus.m_address); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
      checks++;
      if (bus.m_write_n !== 1'b1 || bus.m_byteenable_n !== 2'b00 || bus.m_writedata !== 16'h0) begin
         errors++;
         $display("FAIL reset_constants: write_n=%0b be_n=%b wdata=%h want 1 00 0000",
                  bus.m_write_n, bus.m_byteenable_n, bus.m_writedata);
      end
      checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic_frame();
      int bad;
      run_frame(25'h100, 25'd4, 2, 1'b0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL basic_timeout: done not seen within budget"); end
      checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL basic_busy_c1: got %0b want 1", busy_c1); end
      checks++; if (readn_c1 !== 1'b0) begin errors++; $display("FAIL basic_read_c1: got read_n=%0b want 0", readn_c1); end
      checks++; if (n_acc !== 4) begin errors++; $display("FAIL basic_reads: got %0d want 4", n_acc); end
      bad = 0;
      for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] !== acc_cyc[0] + i) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_consecutive: %0d gaps want 0", bad); end
      checks++; if (n_pop !== 4) begin errors++; $display("FAIL basic_words: got %0d want 4", n_pop); end
      bad = count_data_errors();
      checks++; if (bad !== 0) begin errors++; $display("FAIL basic_data: %0d mismatches want 0", bad); end
      checks++;
      if (got_q.size() < 2 || got_q[0] !== 16'hE6A5 || got_q[1] !== 16'hE680) begin
         errors++;
         $display("FAIL basic_vectors: got %0d words, first two %p want E6A5 E680", got_q.size(), got_q);
      end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", n_done); end
      checks++; if (done_cyc !== last_pop_cyc + 1) begin errors++; $display("FAIL basic_done_timing: done %0d last pop %0d", done_cyc, last_pop_cyc); end
   endtask

   task automatic test_zero_count();
      run_frame(25'h1234, 25'd0, 2, 1'b0, 0, -1);
      checks++; if (done_c1 !== 1'b1) begin errors++; $display("FAIL zero_done_c1: got %0b want 1", done_c1); end
      checks++; if (busy_c1 !== 1'b0) begin errors++; $display("FAIL zero_busy_c1: got %0b want 0", busy_c1); end
      checks++; if (n_acc !== 0) begin errors++; $display("FAIL zero_reads: got %0d want 0", n_acc); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL zero_done_count: got %0d want 1", n_done); end
   endtask

   task automatic test_wrap();
      run_frame(25'h1FFFFFE, 25'd4, 2, 1'b0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL wrap_timeout: done not seen within budget"); end
      checks++;
      if (acc_addr.size() !== 4 || acc_addr[0] !== 25'h1FFFFFE || acc_addr[1] !== 25'h1FFFFFF ||
          acc_addr[2] !== 25'h0 || acc_addr[3] !== 25'h1) begin
         errors++;
         $display("FAIL wrap_addr: got %p want 1fffffe 1ffffff 0 1", acc_addr);
      end
      checks++; if (count_data_errors() !== 0) begin errors++; $display("FAIL wrap_data: %0d mismatches want 0", count_data_errors()); end
   endtask

   task automatic test_backpressure();
      run_frame(25'h2000, 25'd64, 3, 1'b0, 40, -1);
      checks++; if (timeout) begin errors++; $display("FAIL bp_timeout: done not seen within budget"); end
      checks++; if (max_pend > 8) begin errors++; $display("FAIL bp_pend: max %0d want <=8", max_pend); end
      checks++; if (max_occ !== 16) begin errors++; $display("FAIL bp_occupancy: max %0d want 16", max_occ); end
      checks++; if (n_pop !== 64) begin errors++; $display("FAIL bp_words: got %0d want 64", n_pop); end
      checks++; if (count_data_errors() !== 0) begin errors++; $display("FAIL bp_data: %0d mismatches want 0", count_data_errors()); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL bp_done_count: got %0d want 1", n_done); end
   endtask

   task automatic test_waitrequest();
      run_frame(25'h4000, 25'd32, 2, 1'b1, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL wait_timeout: done not seen within budget"); end
      checks++; if (stall_viol !== 0) begin errors++; $display("FAIL wait_stable: %0d changes during stall want 0", stall_viol); end
      checks++; if (n_acc !== 32) begin errors++; $display("FAIL wait_reads: got %0d want 32", n_acc); end
      checks++; if (count_data_errors() !== 0) begin errors++; $display("FAIL wait_data: %0d mismatches want 0", count_data_errors()); end
   endtask

   task automatic test_pend_cap();
      run_frame(25'h6000, 25'd20, 12, 1'b0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL cap_timeout: done not seen within budget"); end
      checks++; if (max_pend !== 8) begin errors++; $display("FAIL cap_pend: max %0d want 8", max_pend); end
      checks++; if (count_data_errors() !== 0) begin errors++; $display("FAIL cap_data: %0d mismatches want 0", count_data_errors()); end
   endtask

   task automatic test_start_while_busy();
      run_frame(25'h200, 25'd6, 2, 1'b0, 0, 2);
      checks++; if (n_acc !== 6) begin errors++; $display("FAIL spur_reads: got %0d want 6", n_acc); end
      checks++; if (count_data_errors() !== 0) begin errors++; $display("FAIL spur_data: %0d mismatches want 0", count_data_errors()); end
      checks++; if (n_done !== 1) begin errors++; $display("FAIL spur_done_count: got %0d want 1", n_done); end
   endtask

   task automatic test_back_to_back();
      run_frame(25'h500, 25'd3, 2, 1'b0, 0, -1);
      run_frame(25'h600, 25'd3, 2, 1'b0, 0, -1);
      checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL b2b_busy_c1: got %0b want 1", busy_c1); end
      checks++; if (count_data_errors() !== 0) begin errors++; $display("FAIL b2b_data: %0d mismatches want 0", count_data_errors()); end
   endtask

   task automatic test_reset_mid_frame();
      int bad;
      bit to;
      latency = 2; wait_en = 1'b0; ready_at = cyc;
      clear_scoreboard();
      bus.base_addr = 25'h300; bus.word_count = 25'd100; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (n_pop >= 10) begin
            to = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
      checks++; if (to) begin errors++; $display("FAIL rst_mid_progress: only %0d words seen", n_pop); end
      bad = 0;
      for (int i = 0; i < 10; i++) if (i >= got_q.size() || got_q[i] !== mem_word(25'h300 + 25'(i))) bad++;
      checks++; if (bad !== 0) begin errors++; $display("FAIL rst_mid_prefix: %0d mismatches want 0", bad); end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.m_read_n !== 1'b1 || bus.m_chipselect !== 1'b0 ||
          bus.m_address !== 25'h0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_outputs: busy=%0b done=%0b read_n=%0b cs=%0b addr=%h valid=%0b want 0 0 1 0 0 0",
                  bus.busy, bus.done, bus.m_read_n, bus.m_chipselect, bus.m_address, bus.out_valid);
      end
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid: got %0b want 0", bus.out_valid); end
      run_frame(25'h40, 25'd8, 2, 1'b0, 0, -1);
      checks++; if (timeout) begin errors++; $display("FAIL rst_fresh_timeout: done not seen within budget"); end
      checks++; if (n_pop !== 8) begin errors++; $display("FAIL rst_fresh_words: got %0d want 8", n_pop); end
      checks++; if (count_data_errors() !== 0) begin errors++; $display("FAIL rst_fresh_data: %0d mismatches want 0", count_data_errors()); end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_zero_count();
      test_wrap();
      test_backpressure();
      test_waitrequest();
      test_pend_cap();
      test_start_while_busy();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
